// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I-subset core: drives all datapath enables and selects.
// Optional macro CTRL_BNE_EN makes bne legal in BRANCH; undefined, bne traps.
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        Z,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        adr_sel,
  output logic        dmem_wren,
  output logic        ir_wren,
  output logic        pc_wren,
  output logic        regfile_wren,
  output logic [1:0]  alu_asel,
  output logic [1:0]  alu_bsel,
  output logic [1:0]  ximm_sel,
  output logic [2:0]  alu_control,
  output logic [1:0]  result_sel,
  output logic        trap
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExR, StExI, StAluWb, StBranch, StJal, StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [2:0] f3_op;
  logic       f3_ok;
  logic       wait_expired;
  logic       unused_instr;

  assign opcode       = instruction[6:0];
  assign funct3       = instruction[14:12];
  assign funct7_b5    = instruction[30];
  assign wait_expired = (wait_q == WaitLimit) && !mem_ready;
  assign unused_instr = ^{instruction[31], instruction[29:15], instruction[11:7]};

  // funct3 -> ALU op shared by EXR and EXI; sub is layered on top for EXR only.
  always_comb begin
    f3_op = AluAdd;
    f3_ok = 1'b1;
    case (funct3)
      3'b000:  f3_op = AluAdd;
      3'b111:  f3_op = AluAnd;
      3'b110:  f3_op = AluOr;
      3'b010:  f3_op = AluSlt;
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    mem_req      = 1'b0;
    adr_sel      = 1'b0;
    dmem_wren    = 1'b0;
    ir_wren      = 1'b0;
    pc_wren      = 1'b0;
    regfile_wren = 1'b0;
    alu_asel     = 2'b00;
    alu_bsel     = 2'b00;
    ximm_sel     = 2'b00;
    alu_control  = AluAdd;
    result_sel   = 2'b00;
    trap         = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        alu_bsel   = 2'b10;
        result_sel = 2'b10;
        if (mem_ready) begin
          ir_wren = 1'b1;
          pc_wren = 1'b1;
          state_d = StDecode;
        end else if (wait_expired) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        alu_asel = 2'b01;
        alu_bsel = 2'b01;
        ximm_sel = (opcode == OpJal) ? 2'b11 : 2'b10;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpReg:           state_d = StExR;
          OpImm:           state_d = StExI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_asel = 2'b10;
        alu_bsel = 2'b01;
        ximm_sel = (opcode == OpStore) ? 2'b01 : 2'b00;
        state_d  = (opcode == OpStore) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_req = 1'b1;
        adr_sel = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (wait_expired) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StMemWb: begin
        result_sel   = 2'b01;
        regfile_wren = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        mem_req   = 1'b1;
        adr_sel   = 1'b1;
        dmem_wren = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
        end else if (wait_expired) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StExR: begin
        alu_asel    = 2'b10;
        alu_control = (funct3 == 3'b000 && funct7_b5) ? AluSub : f3_op;
        state_d     = (f3_ok && (!funct7_b5 || funct3 == 3'b000)) ? StAluWb : StTrap;
      end
      StExI: begin
        alu_asel    = 2'b10;
        alu_bsel    = 2'b01;
        alu_control = f3_op;
        state_d     = f3_ok ? StAluWb : StTrap;
      end
      StAluWb: begin
        regfile_wren = 1'b1;
        state_d      = StFetch;
      end
      StBranch: begin
        alu_asel    = 2'b10;
        alu_control = AluSub;
        case (funct3)
          3'b000: begin
            pc_wren = Z;
            state_d = StFetch;
          end
`ifdef CTRL_BNE_EN
          3'b001: begin
            pc_wren = ~Z;
            state_d = StFetch;
          end
`endif
          default: state_d = StTrap;
        endcase
      end
      StJal: begin
        alu_asel = 2'b01;
        alu_bsel = 2'b10;
        pc_wren  = 1'b1;
        state_d  = StAluWb;
      end
      StTrap: begin
        trap = 1'b1;
      end
      default: state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: every output is packed into one vector per cycle
// and compared against hand-derived per-state values.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        Z;
  logic        mem_ready;
  logic        mem_req, adr_sel, dmem_wren, ir_wren, pc_wren, regfile_wren, trap;
  logic [1:0]  alu_asel, alu_bsel, ximm_sel, result_sel;
  logic [2:0]  alu_control;
  logic [17:0] vec;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.WAIT_LIMIT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .Z            (Z),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .adr_sel      (adr_sel),
    .dmem_wren    (dmem_wren),
    .ir_wren      (ir_wren),
    .pc_wren      (pc_wren),
    .regfile_wren (regfile_wren),
    .alu_asel     (alu_asel),
    .alu_bsel     (alu_bsel),
    .ximm_sel     (ximm_sel),
    .alu_control  (alu_control),
    .result_sel   (result_sel),
    .trap         (trap)
  );

  // {mem_req, adr_sel, dmem_wren, ir_wren, pc_wren, regfile_wren,
  //  asel[2], bsel[2], ximm[2], alu_control[3], result_sel[2], trap}
  assign vec = {mem_req, adr_sel, dmem_wren, ir_wren, pc_wren, regfile_wren,
                alu_asel, alu_bsel, ximm_sel, alu_control, result_sel, trap};

  localparam logic [17:0] ExpFetchWait =
    {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 1'b0};
  localparam logic [17:0] ExpFetchGo =
    {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 1'b0};
  localparam logic [17:0] ExpDecodeB =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] ExpDecodeJ =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b11, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] ExpMemAdrLw =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] ExpMemAdrSw =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] ExpMemRd =
    {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] ExpMemWb =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0};
  localparam logic [17:0] ExpMemWr =
    {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] ExpExRSub =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 2'b00, 1'b0};
  localparam logic [17:0] ExpExIAdd =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] ExpAluWb =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] ExpBranchT =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 2'b00, 1'b0};
  localparam logic [17:0] ExpBranchN =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 2'b00, 1'b0};
  localparam logic [17:0] ExpJal =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] ExpTrap =
    {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1};

  localparam logic [31:0] InsLw   = 32'h0080_2283;  // lw   x5,8(x0)
  localparam logic [31:0] InsSw   = 32'h0020_A223;  // sw   x2,4(x1)
  localparam logic [31:0] InsSub  = 32'h4020_81B3;  // sub  x3,x1,x2
  localparam logic [31:0] InsAddi = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] InsJal  = 32'h0000_00EF;  // jal  x1,0
  localparam logic [31:0] InsBeq  = 32'h0020_8063;  // beq  x1,x2,0
  localparam logic [31:0] InsBne  = 32'h0020_9063;  // bne  x1,x2,0
  localparam logic [31:0] InsBad  = 32'h0000_0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are compared 1 time unit later.
  task automatic cyc(input string tag, input logic [17:0] exp);
    #1;
    check_eq(tag, {14'd0, vec}, {14'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] ins);
    instruction = ins;
    mem_ready   = 1'b1;
    cyc(tag, ExpFetchGo);
  endtask

  initial begin
    reset       = 1'b1;
    instruction = '0;
    Z           = 1'b0;
    mem_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    cyc("reset_fetch", ExpFetchWait);

    fetch("lw_fetch", InsLw);
    cyc("lw_decode", ExpDecodeB);
    cyc("lw_memadr", ExpMemAdrLw);
    cyc("lw_memrd", ExpMemRd);
    cyc("lw_memwb", ExpMemWb);

    fetch("sub_fetch", InsSub);
    cyc("sub_decode", ExpDecodeB);
    cyc("sub_exr", ExpExRSub);
    cyc("sub_aluwb", ExpAluWb);

    fetch("addi_fetch", InsAddi);
    cyc("addi_decode", ExpDecodeB);
    cyc("addi_exi", ExpExIAdd);
    cyc("addi_aluwb", ExpAluWb);

    fetch("jal_fetch", InsJal);
    cyc("jal_decode", ExpDecodeJ);
    cyc("jal_jal", ExpJal);
    cyc("jal_aluwb", ExpAluWb);

    Z = 1'b1;
    fetch("beq_t_fetch", InsBeq);
    cyc("beq_t_decode", ExpDecodeB);
    cyc("beq_t_branch", ExpBranchT);
    Z = 1'b0;
    fetch("beq_n_fetch", InsBeq);
    cyc("beq_n_decode", ExpDecodeB);
    cyc("beq_n_branch", ExpBranchN);

    fetch("sw_fetch", InsSw);
    cyc("sw_decode", ExpDecodeB);
    cyc("sw_memadr", ExpMemAdrSw);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("sw_wait%0d", i), ExpMemWr);
    mem_ready = 1'b1;
    cyc("sw_done", ExpMemWr);
    mem_ready = 1'b0;
    cyc("sw_back_fetch", ExpFetchWait);

    // Reset in the middle of a store must drop dmem_wren and restart at FETCH.
    fetch("swr_fetch", InsSw);
    cyc("swr_decode", ExpDecodeB);
    cyc("swr_memadr", ExpMemAdrSw);
    mem_ready = 1'b0;
    cyc("swr_memwr", ExpMemWr);
    reset = 1'b1;
    cyc("swr_rst_cycle", ExpMemWr);
    reset = 1'b0;
    cyc("swr_after_rst", ExpFetchWait);

    Z = 1'b0;
    fetch("bne_fetch", InsBne);
    cyc("bne_decode", ExpDecodeB);
`ifdef CTRL_BNE_EN
    cyc("bne_branch", ExpBranchT);
    mem_ready = 1'b0;
    cyc("bne_back_fetch", ExpFetchWait);
`else
    cyc("bne_branch", ExpBranchN);
    cyc("bne_trap", ExpTrap);
    reset = 1'b1;
    cyc("bne_rst_cycle", ExpTrap);
    reset     = 1'b0;
    mem_ready = 1'b0;
    cyc("bne_after_rst", ExpFetchWait);
`endif

    fetch("bad_fetch", InsBad);
    cyc("bad_decode", ExpDecodeB);
    cyc("bad_trap", ExpTrap);
    mem_ready = 1'b1;
    cyc("bad_trap_hold1", ExpTrap);
    mem_ready = 1'b0;
    cyc("bad_trap_hold2", ExpTrap);
    reset = 1'b1;
    cyc("bad_rst_cycle", ExpTrap);
    reset = 1'b0;
    cyc("bad_after_rst", ExpFetchWait);

    // Store that never completes: WAIT_LIMIT+1 cycles in MEMWR, then TRAP.
    fetch("swt_fetch", InsSw);
    cyc("swt_decode", ExpDecodeB);
    cyc("swt_memadr", ExpMemAdrSw);
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc($sformatf("swt_wait%0d", i), ExpMemWr);
    cyc("swt_trap", ExpTrap);
    cyc("swt_trap_hold", ExpTrap);
    reset = 1'b1;
    cyc("swt_rst_cycle", ExpTrap);
    reset = 1'b0;
    cyc("swt_after_rst", ExpFetchWait);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
